pio_pixel_feeder: RTL and testbench

Consumes the 8-bit HPS PIO export byte and turns the host's nibble-paced writes into a framed 8-bit pixel stream for the downstream image filter.
- Decodes a toggle-strobed command byte.
- Assembles pixels from two nibbles and buffers them in a small FIFO.
- Emits valid/ready pixels with start-of-frame, end-of-line and end-of-frame markers.

---
 rtl/pio_pixel_feeder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_pio_pixel_feeder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_pixel_feeder.sv
// Turns toggle-strobed HPS PIO nibble writes into a framed valid/ready pixel stream with sof/eol/eof tags.
// Build option PIO_INPUT_SYNC_EN adds a 2-flop input synchronizer for a PIO in a foreign clock domain.
`default_nettype none

module pio_pixel_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_dat_i,
    input  logic                     pop_i,
    output logic [W-1:0]             pop_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign do_pop    = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push   = push_i && (!full_o || do_pop);
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign level_o   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end
endmodule

module pio_pixel_feeder #(
    parameter int LINE_W     = 640,
    parameter int N_LINES    = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic [7:0]                    pio_byte,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sof,
    output logic                          out_eol,
    output logic                          out_eof,
    output logic [1:0]                    filt_mode,
    output logic                          busy,
    output logic                          overflow,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int COL_W = $clog2(LINE_W);
    localparam int ROW_W = (N_LINES > 1) ? $clog2(N_LINES) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [2:0] OP_NIBBLE   = 3'd1;
    localparam logic [2:0] OP_START    = 3'd2;
    localparam logic [2:0] OP_ABORT    = 3'd3;
    localparam logic [2:0] OP_SET_MODE = 3'd4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RECV_LO = 2'd1;
    localparam logic [1:0] ST_RECV_HI = 2'd2;

    logic [7:0] pio_src;

`ifdef PIO_INPUT_SYNC_EN
    logic [7:0] sync1_q, sync2_q;
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pio_byte;
            sync2_q <= sync1_q;
        end
    end
    assign pio_src = sync2_q;
`else
    assign pio_src = pio_byte;
`endif

    logic [7:0]       pio_q;
    logic             last_tgl_q;
    logic [1:0]       state_q, state_d;
    logic [3:0]       lo_q, lo_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [1:0]       mode_q, mode_d;
    logic             ovf_q, ovf_d;
    logic             frame_done_q;

    logic             evt;
    logic [2:0]       op;
    logic [3:0]       dat;
    logic             last_col, last_row;
    logic             tag_sof, tag_eol, tag_eof;
    logic             push, flush, pop;
    logic [10:0]      push_dat, head;
    logic             fifo_full, fifo_empty;
    logic [LVL_W-1:0] level;

    // The byte is registered once before decode, so a write lands in the FIFO one edge after it is sampled.
    assign evt = pio_q[7] ^ last_tgl_q;
    assign op  = pio_q[6:4];
    assign dat = pio_q[3:0];

    assign last_col = (col_q == COL_W'(LINE_W - 1));
    assign last_row = (row_q == ROW_W'(N_LINES - 1));
    assign tag_sof  = (col_q == '0) && (row_q == '0);
    assign tag_eol  = last_col;
    assign tag_eof  = last_col && last_row;
    assign push_dat = {tag_sof, tag_eol, tag_eof, dat, lo_q};

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        col_d   = col_q;
        row_d   = row_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (evt) begin
            if (op == OP_ABORT) begin
                state_d = ST_IDLE;
                flush   = 1'b1;
                col_d   = '0;
                row_d   = '0;
                lo_d    = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (op == OP_START) begin
                            state_d = ST_RECV_LO;
                            ovf_d   = 1'b0;
                            col_d   = '0;
                            row_d   = '0;
                        end else if (op == OP_SET_MODE) begin
                            mode_d = dat[1:0];
                        end
                    end
                    ST_RECV_LO: begin
                        if (op == OP_NIBBLE) begin
                            lo_d    = dat;
                            state_d = ST_RECV_HI;
                        end
                    end
                    ST_RECV_HI: begin
                        if (op == OP_NIBBLE) begin
                            // Counters advance even if the FIFO drops this pixel, keeping framing aligned with the host.
                            push    = 1'b1;
                            state_d = ST_RECV_LO;
                            if (last_col) begin
                                col_d = '0;
                                if (last_row) begin
                                    row_d   = '0;
                                    state_d = ST_IDLE;
                                end else begin
                                    row_d = row_q + 1'b1;
                                end
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            pio_q        <= '0;
            last_tgl_q   <= 1'b0;
            state_q      <= ST_IDLE;
            lo_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            mode_q       <= '0;
            ovf_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            pio_q        <= pio_src;
            last_tgl_q   <= pio_q[7];
            state_q      <= state_d;
            lo_q         <= lo_d;
            col_q        <= col_d;
            row_q        <= row_d;
            mode_q       <= mode_d;
            ovf_q        <= ovf_d;
            frame_done_q <= pop && head[8];
        end
    end

    pio_pixel_fifo #(
        .W     (11),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_clk),
        .rst_i      (reset_reset),
        .flush_i    (flush),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .pop_dat_o  (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (level)
    );

    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    // Head storage is not reset; gate it so idle outputs read as zero.
    assign out_data   = out_valid ? head[7:0] : 8'h00;
    assign out_sof    = out_valid && head[10];
    assign out_eol    = out_valid && head[9];
    assign out_eof    = out_valid && head[8];
    assign filt_mode  = mode_q;
    assign overflow   = ovf_q;
    assign frame_done = frame_done_q;
    assign fifo_level = level;
    assign busy       = (state_q != ST_IDLE) || (level != '0);
endmodule

`default_nettype wire

// File: tb/tb_pio_pixel_feeder.sv
// Directed bench for pio_pixel_feeder (LINE_W=4, N_LINES=2, FIFO_DEPTH=4) with a queue-based framing model.
module tb_pio_pixel_feeder;
    localparam int LW    = 4;
    localparam int NL    = 2;
    localparam int DEP   = 4;
    localparam int TOTAL = LW * NL;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pio_byte = 8'h00;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, out_sof, out_eol, out_eof;
    logic [1:0] filt_mode;
    logic       busy, overflow, frame_done;
    logic [2:0] fifo_level;

    pio_pixel_feeder #(.LINE_W(LW), .N_LINES(NL), .FIFO_DEPTH(DEP)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .pio_byte    (pio_byte),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sof     (out_sof),
        .out_eol     (out_eol),
        .out_eof     (out_eof),
        .filt_mode   (filt_mode),
        .busy        (busy),
        .overflow    (overflow),
        .frame_done  (frame_done),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Host-level model: entries are {sof, eol, eof, pixel}.
    logic [10:0] exp_q[$];
    logic [10:0] acc_q[$];
    bit          m_in_frame, m_have_lo, m_ovf, exp_fd;
    logic [3:0]  m_lo;
    logic [1:0]  m_mode;
    int          m_idx;
    int          fd_cnt;
    bit          tgl;

    function automatic void model_reset();
        exp_q.delete();
        m_in_frame = 0; m_have_lo = 0; m_ovf = 0; exp_fd = 0;
        m_lo = 4'h0; m_mode = 2'd0; m_idx = 0;
    endfunction

    function automatic void model_apply(input logic [2:0] op, input logic [3:0] d);
        logic [7:0] px;
        case (op)
            3'd2: if (!m_in_frame) begin
                m_in_frame = 1; m_have_lo = 0; m_idx = 0; m_ovf = 0;
            end
            3'd3: begin
                m_in_frame = 0; m_have_lo = 0; m_idx = 0; exp_q.delete();
            end
            3'd4: if (!m_in_frame) m_mode = d[1:0];
            3'd1: if (m_in_frame) begin
                if (!m_have_lo) begin
                    m_lo = d; m_have_lo = 1;
                end else begin
                    px = {d, m_lo};
                    if (exp_q.size() == DEP) m_ovf = 1;
                    else exp_q.push_back({m_idx == 0, (m_idx % LW) == LW - 1, m_idx == TOTAL - 1, px});
                    m_have_lo = 0;
                    m_idx++;
                    if (m_idx == TOTAL) begin
                        m_in_frame = 0; m_idx = 0;
                    end
                end
            end
            default: ;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0)
                chk("pixel", {out_sof, out_eol, out_eof, out_data}, exp_q[0]);
            chk("fifo_level", fifo_level, exp_q.size());
            chk("busy", busy, m_in_frame || exp_q.size() != 0);
            chk("overflow", overflow, m_ovf);
            chk("filt_mode", filt_mode, m_mode);
            chk("frame_done", frame_done, exp_fd);
            if (frame_done) fd_cnt++;
            exp_fd = 0;
            if (out_valid && out_ready && exp_q.size() != 0) begin
                exp_fd = exp_q[0][8];
                acc_q.push_back({out_sof, out_eol, out_eof, out_data});
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [3:0] d);
        @(posedge clk);
        #2;
        tgl = ~tgl;
        pio_byte = {tgl, op, d};
        @(posedge clk);
`ifdef PIO_INPUT_SYNC_EN
        repeat (2) @(posedge clk);
`endif
        @(posedge clk);
        model_apply(op, d);
    endtask

    task automatic send_pix(input logic [7:0] p);
        send(3'd1, p[3:0]);
        send(3'd1, p[7:4]);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        chk("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic chk_acc(input string name, input int idx, input logic [10:0] want);
        if (idx < acc_q.size()) chk(name, acc_q[idx], want);
        else chk({name, "_missing"}, 32'hdead, want);
    endtask

    logic [10:0] t1_want [8] = '{11'h410, 11'h011, 11'h012, 11'h213,
                                 11'h014, 11'h015, 11'h016, 11'h317};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tgl = 0;
        model_reset();
        fd_cnt = 0;
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_mode", filt_mode, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Full 4x2 frame with ready held high.
        out_ready = 1'b1;
        acc_q.delete(); fd_cnt = 0;
        send(3'd2, 4'h0);
        for (int i = 0; i < 8; i++) send_pix(8'h10 + 8'(i));
        drain();
        chk("t1_count", acc_q.size(), 8);
        for (int i = 0; i < 8; i++) chk_acc("t1_stream", i, t1_want[i]);
        chk("t1_frame_done", fd_cnt, 1);
        chk("t1_busy", busy, 0);

        // Toggle timing on a single hi-nibble event, FIFO empty.
        out_ready = 1'b0;
        send(3'd2, 4'h0);
        send(3'd1, 4'hC);
        @(posedge clk);
        #2;
        tgl = ~tgl;
        pio_byte = {tgl, 3'd1, 4'h3};
        @(posedge clk);
`ifdef PIO_INPUT_SYNC_EN
        repeat (2) @(posedge clk);
`endif
        #1 chk("t2_not_yet", out_valid, 0);
        @(posedge clk);
        model_apply(3'd1, 4'h3);
        #1;
        chk("t2_rise", out_valid, 1);
        chk("t2_pixel", {out_sof, out_eol, out_eof, out_data}, 11'h43C);
        repeat (6) @(posedge clk);
        #1 chk("t2_static", fifo_level, 1);
        send(3'd3, 4'h0);

        // Overflow with ready low, then drain and finish the frame.
        send(3'd2, 4'h0);
        for (int i = 0; i < 6; i++) send_pix(8'h20 + 8'(i));
        #1;
        chk("t3_level", fifo_level, 4);
        chk("t3_ovf", overflow, 1);
        acc_q.delete();
        #1 out_ready = 1'b1;
        drain();
        chk("t3_count", acc_q.size(), 4);
        chk_acc("t3_p0", 0, 11'h420);
        chk_acc("t3_p1", 1, 11'h021);
        chk_acc("t3_p2", 2, 11'h022);
        chk_acc("t3_p3", 3, 11'h223);
        acc_q.delete();
        send_pix(8'h26);
        send_pix(8'h27);
        drain();
        chk_acc("t3_p6", 0, 11'h026);
        chk_acc("t3_p7", 1, 11'h327);
        chk("t3_ovf_sticky", overflow, 1);

        // Abort with 3 pixels queued and a nibble pending.
        out_ready = 1'b0;
        send(3'd2, 4'h0);
        send_pix(8'h30); send_pix(8'h31); send_pix(8'h32);
        send(3'd1, 4'h3);
        send(3'd3, 4'h0);
        #1;
        chk("t4_valid", out_valid, 0);
        chk("t4_level", fifo_level, 0);
        chk("t4_busy", busy, 0);
        out_ready = 1'b1;
        acc_q.delete();
        send(3'd2, 4'h0);
        send_pix(8'h40);
        drain();
        chk_acc("t4_sof", 0, 11'h440);
        send(3'd3, 4'h0);

        // SET_MODE only in IDLE; START mid-frame ignored.
        send(3'd4, 4'h2);
        #1 chk("t5_mode_idle", filt_mode, 2);
        send(3'd2, 4'h0);
        send(3'd4, 4'h1);
        #1 chk("t5_mode_busy", filt_mode, 2);
        acc_q.delete();
        send_pix(8'h50);
        send(3'd2, 4'h0);
        send_pix(8'h51);
        drain();
        chk_acc("t5_p0", 0, 11'h450);
        chk_acc("t5_p1", 1, 11'h051);
        send(3'd3, 4'h0);

        // Asynchronous reset mid-frame with FIFO full and overflow set.
        send(3'd4, 4'h3);
        out_ready = 1'b0;
        send(3'd2, 4'h0);
        for (int i = 0; i < 5; i++) send_pix(8'h60 + 8'(i));
        #1 chk("t6_ovf_before", overflow, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_data", out_data, 0);
        chk("t6_tags", {out_sof, out_eol, out_eof}, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_busy", busy, 0);
        chk("t6_fd", frame_done, 0);
        chk("t6_mode", filt_mode, 0);
        model_reset();
        tgl = 0;
        pio_byte = 8'h00;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        acc_q.delete();
        send(3'd2, 4'h0);
        send_pix(8'h70);
        drain();
        chk_acc("t6_after", 0, 11'h470);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
